// File: rtl/pe_inj_arb_if.sv
// pe_inj_arb_if: request, injection and statistics signals of the PE injection arbiter.
// The statistics signals exist only when PE_INJ_ARB_STATS_EN is defined.
// master drives requests and switch readiness; slave is the arbiter.
interface pe_inj_arb_if #(
    parameter int N_REQ = 4,
    parameter int P_W   = 16,
    parameter int CNT_W = 16
);
    logic [N_REQ*P_W-1:0]   req_pkt;
    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ-1:0]       req_ack;
    logic                   sw_rdy;
    logic [P_W-1:0]         out_pkt;
    logic                   out_vld;
`ifdef PE_INJ_ARB_STATS_EN
    logic [N_REQ*CNT_W-1:0] stat_cnt;
    logic [CNT_W-1:0]       stall_max;

    modport master (output req_pkt, req_vld, sw_rdy,
                     input  req_ack, out_pkt, out_vld, stat_cnt, stall_max);
    modport slave  (input  req_pkt, req_vld, sw_rdy,
                     output req_ack, out_pkt, out_vld, stat_cnt, stall_max);
`else
    modport master (output req_pkt, req_vld, sw_rdy,
                     input  req_ack, out_pkt, out_vld);
    modport slave  (input  req_pkt, req_vld, sw_rdy,
                     output req_ack, out_pkt, out_vld);
`endif

    // The counter width must be usable whenever statistics are built in.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pe_inj_arb_if: CNT_W must be at least 1");
    end
endinterface

// File: rtl/pe_inj_arb.sv
// pe_inj_arb: round-robin injection arbiter from N_REQ local packet sources
// onto the single PE injection port of a torus switch.  The winner is
// registered and held until the switch takes it with sw_rdy.
// Optional statistics (per-source packet counts and the longest sw_rdy
// stall) are built in when the macro PE_INJ_ARB_STATS_EN is defined.
module pe_inj_arb #(
    parameter int P_W   = 16,
    parameter int X_AW  = 2,
    parameter int Y_AW  = 2,
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    pe_inj_arb_if.slave bus
);
    localparam int PTR_W  = $clog2(N_REQ);
    localparam int ADDR_W = X_AW + Y_AW;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic               grant_vld;
    logic [N_REQ-1:0]   grant_oh;
    logic [P_W-1:0]     grant_pkt;
    logic [P_W-1:0]     out_pkt;
    logic               out_vld;
    logic               tran_done;
    logic               can_load;
    logic               load;

    // Parameter sanity: the address must fit in the packet and the requester count is bounded.
    if (ADDR_W > P_W || N_REQ < 2 || N_REQ > 16 || CNT_W < 1) begin : g_bad_params
        $error("pe_inj_arb: illegal parameter combination");
    end

    assign out_vld   = (state_q == FULL);
    assign tran_done = out_vld & bus.sw_rdy;
    assign can_load  = !out_vld | tran_done;

    // Round-robin search: first valid requester at or above ptr, otherwise first valid from 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_vld && bus.req_vld[i] && (PTR_W'(i) >= ptr)) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_vld && bus.req_vld[i]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
    end

    // One-hot grant and the winning packet selected from the flat request bus.
    always_comb begin
        grant_oh  = '0;
        grant_pkt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vld && (grant_idx == PTR_W'(i))) begin
                grant_oh[i] = 1'b1;
                grant_pkt   = bus.req_pkt[i*P_W +: P_W];
            end
        end
    end

    assign bus.req_ack = (can_load && !rst) ? grant_oh : '0;
    assign load        = |(bus.req_vld & bus.req_ack);
    assign ptr_next    = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // Output occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy transitions: fill on a load, drain only when the switch takes the packet and nothing replaces it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (tran_done && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Capture the winning packet and advance the pointer past the winner on every load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pkt <= '0;
            ptr     <= '0;
        end else if (load) begin
            out_pkt <= grant_pkt;
            ptr     <= ptr_next;
        end
    end

    assign bus.out_pkt = out_pkt;
    assign bus.out_vld = out_vld;

`ifdef PE_INJ_ARB_STATS_EN
    logic [PTR_W-1:0]       src_q;
    logic [N_REQ*CNT_W-1:0] stat_cnt;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       stall_max;
    logic                   stall_step;

    assign stall_step = out_vld && !bus.sw_rdy && (stall_cnt != '1);

    // Remember which requester the held packet came from and count it when the switch takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            stat_cnt <= '0;
        end else begin
            if (load) begin
                src_q <= grant_idx;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (tran_done && (src_q == PTR_W'(i)) && (stat_cnt[i*CNT_W +: CNT_W] != '1)) begin
                    stat_cnt[i*CNT_W +: CNT_W] <= stat_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // Track the current run of stalled cycles and the longest run seen, both saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            stall_max <= '0;
        end else begin
            if (tran_done) begin
                stall_cnt <= '0;
            end else if (stall_step) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (stall_step && (stall_max < stall_cnt + CNT_W'(1))) begin
                stall_max <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stat_cnt  = stat_cnt;
    assign bus.stall_max = stall_max;
`endif
endmodule

// File: tb/tb_pe_inj_arb.sv
// tb_pe_inj_arb: directed test of pe_inj_arb with a 4-requester and a
// 3-requester instance.  Statistics checks run when PE_INJ_ARB_STATS_EN is defined.
module tb_pe_inj_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passCount  = 0;
    int   failCount  = 0;
    int   checkCount = 0;

    always #5 clk = ~clk;

    pe_inj_arb_if #(.N_REQ(4), .P_W(16), .CNT_W(16)) bus4 ();
    pe_inj_arb_if #(.N_REQ(3), .P_W(16), .CNT_W(16)) bus3 ();

    pe_inj_arb #(.P_W(16), .X_AW(2), .Y_AW(2), .N_REQ(4), .CNT_W(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    pe_inj_arb #(.P_W(16), .X_AW(2), .Y_AW(2), .N_REQ(3), .CNT_W(16)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] vld, input logic rdy);
        bus4.req_vld = vld;
        bus4.sw_rdy  = rdy;
        #1;
    endtask

    task automatic setPkt4(input int idx, input logic [15:0] pkt);
        bus4.req_pkt[idx*16 +: 16] = pkt;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus4.req_pkt = '0;
        bus4.req_vld = '0;
        bus4.sw_rdy  = 1'b0;
        bus3.req_pkt = '0;
        bus3.req_vld = '0;
        bus3.sw_rdy  = 1'b0;

        // Reset with all requests asserted: acks must stay low while rst is high.
        rst = 1'b1;
        bus4.req_vld = 4'b1111;
        stepClock();
        stepClock();
        checkOutput("rst_out_vld", 64'(bus4.out_vld), 64'h0);
        checkOutput("rst_out_pkt", 64'(bus4.out_pkt), 64'h0);
        checkOutput("rst_req_ack", 64'(bus4.req_ack), 64'h0);
        checkOutput("rst3_out_vld", 64'(bus3.out_vld), 64'h0);
        rst = 1'b0;

        // Single requester: one ack, packet appears next cycle, then drains.
        setPkt4(0, 16'h5003);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("single_ack", 64'(bus4.req_ack), 64'h1);
        stepClock();
        checkOutput("single_pkt", 64'(bus4.out_pkt), 64'h5003);
        checkOutput("single_vld", 64'(bus4.out_vld), 64'h1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("single_ack_off", 64'(bus4.req_ack), 64'h0);
        stepClock();
        checkOutput("single_drain_vld", 64'(bus4.out_vld), 64'h0);
        checkOutput("single_hold_pkt", 64'(bus4.out_pkt), 64'h5003);

        // Return pointer to 0 before the fairness run.
        rst = 1'b1;
        stepClock();
        rst = 1'b0;

        // Fairness: all valid, switch always ready -> grants 0,1,2,3,0,1 with no bubble.
        setPkt4(0, 16'hA100);
        setPkt4(1, 16'hA101);
        setPkt4(2, 16'hA102);
        setPkt4(3, 16'hA103);
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkOutput("fair_ack", 64'(bus4.req_ack), 64'(4'b0001 << (k % 4)));
            stepClock();
            checkOutput("fair_vld", 64'(bus4.out_vld), 64'h1);
            checkOutput("fair_pkt", 64'(bus4.out_pkt), 64'h0000_0000_0000_A100 + 64'(k % 4));
        end

        // Backpressure: A101 held for 5 stalled cycles, then requester 2 loads on the release edge.
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_ack", 64'(bus4.req_ack), 64'h0);
            stepClock();
            checkOutput("bp_pkt", 64'(bus4.out_pkt), 64'hA101);
            checkOutput("bp_vld", 64'(bus4.out_vld), 64'h1);
        end
        applyStimulus(4'b1111, 1'b1);
        checkOutput("bp_release_ack", 64'(bus4.req_ack), 64'h4);
        stepClock();
        checkOutput("bp_release_pkt", 64'(bus4.out_pkt), 64'hA102);

        // Reset mid-stall: held packet discarded, pointer back to 0.
        applyStimulus(4'b1111, 1'b0);
        stepClock();
        checkOutput("stall_hold_pkt", 64'(bus4.out_pkt), 64'hA102);
        rst = 1'b1;
        #1;
        checkOutput("rst_gate_ack", 64'(bus4.req_ack), 64'h0);
        stepClock();
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1);
        checkOutput("midrst_vld", 64'(bus4.out_vld), 64'h0);
        checkOutput("midrst_pkt", 64'(bus4.out_pkt), 64'h0);
        stepClock();
        checkOutput("empty_rdy_ignored", 64'(bus4.out_vld), 64'h0);
`ifdef PE_INJ_ARB_STATS_EN
        checkOutput("midrst_stat_cnt", 64'(bus4.stat_cnt), 64'h0);
        checkOutput("midrst_stall_max", 64'(bus4.stall_max), 64'h0);
`endif
        applyStimulus(4'b1111, 1'b0);
        checkOutput("midrst_ptr0_ack", 64'(bus4.req_ack), 64'h1);
        applyStimulus(4'b0000, 1'b0);
        stepClock();

        // Requester 1 sends three packets; the second is stalled for 7 cycles.
        setPkt4(1, 16'hB001);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("st_ack1", 64'(bus4.req_ack), 64'h2);
        stepClock();
        checkOutput("st_pkt1", 64'(bus4.out_pkt), 64'hB001);
        setPkt4(1, 16'hB002);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("st_ack2", 64'(bus4.req_ack), 64'h2);
        stepClock();
        checkOutput("st_pkt2", 64'(bus4.out_pkt), 64'hB002);
        applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 7; k++) begin
            stepClock();
        end
        checkOutput("st_stall_pkt", 64'(bus4.out_pkt), 64'hB002);
        checkOutput("st_stall_vld", 64'(bus4.out_vld), 64'h1);
        setPkt4(1, 16'hB003);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("st_ack3", 64'(bus4.req_ack), 64'h2);
        stepClock();
        checkOutput("st_pkt3", 64'(bus4.out_pkt), 64'hB003);
        applyStimulus(4'b0000, 1'b1);
        stepClock();
        checkOutput("st_drain_vld", 64'(bus4.out_vld), 64'h0);
`ifdef PE_INJ_ARB_STATS_EN
        checkOutput("st_stat_cnt", 64'(bus4.stat_cnt), 64'h0000_0000_0003_0000);
        checkOutput("st_stall_max", 64'(bus4.stall_max), 64'h7);
`endif

        // Three requesters: granting 2 wraps the pointer to 0, so 0 beats 2 next.
        bus3.req_pkt[2*16 +: 16] = 16'hC002;
        bus3.req_vld = 3'b100;
        bus3.sw_rdy  = 1'b1;
        #1;
        checkOutput("n3_ack2", 64'(bus3.req_ack), 64'h4);
        stepClock();
        checkOutput("n3_pkt2", 64'(bus3.out_pkt), 64'hC002);
        bus3.req_pkt[0 +: 16]    = 16'hC000;
        bus3.req_pkt[2*16 +: 16] = 16'hC012;
        bus3.req_vld = 3'b101;
        #1;
        checkOutput("n3_wrap_ack0", 64'(bus3.req_ack), 64'h1);
        stepClock();
        checkOutput("n3_pkt0", 64'(bus3.out_pkt), 64'hC000);
        checkOutput("n3_next_ack2", 64'(bus3.req_ack), 64'h4);
        stepClock();
        checkOutput("n3_pkt2b", 64'(bus3.out_pkt), 64'hC012);
        bus3.req_vld = 3'b000;
        stepClock();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/pe_inj_arb.md
# pe_inj_arb

Injection arbiter between several local packet sources in a processing element and the single injection port of its torus switch. Up to `N_REQ` requesters present `{addr, data}` packets. The block grants them round-robin and registers the winner onto the switch injection port. The registered packet is held stable until the switch accepts it with `sw_rdy`. The block sits between PE-side traffic generators or compute units and the switch's PE input.

## Interface
- `P_W`, 16: packet width, `{addr, data}`; addr is the top `X_AW+Y_AW` bits.
- `X_AW`, 2: X address width of the torus.
- `Y_AW`, 2: Y address width of the torus.
- `N_REQ`, 4: number of requesters, 2..16; need not be a power of two.
- `CNT_W`, 16: statistics counter width (only with `PE_INJ_ARB_STATS_EN`).

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_pkt` in `N_REQ*P_W`: packet of requester i in bits `[i*P_W +: P_W]`.
- `req_vld` in `N_REQ`: requester i has a packet.
- `req_ack` out `N_REQ`: combinational; transfer from i occurs on an edge where `req_vld[i] & req_ack[i]`.
- `sw_rdy` in 1: switch accepted the injected packet.
- `out_pkt` out `P_W`: registered packet to the switch.
- `out_vld` out 1: registered valid to the switch.
- `stat_cnt` out `N_REQ*CNT_W`: per-requester injected-packet counts (only with the macro).
- `stall_max` out `CNT_W`: longest observed `sw_rdy` stall in cycles (only with the macro).

## Operation
- `tran_done = out_vld & sw_rdy`: the switch takes `out_pkt` on this edge.
- `can_load = !out_vld | tran_done`: the output register is free on this edge.
- Round-robin pointer `ptr` (`$clog2(N_REQ)` bits, reset 0).
  - Grant goes to the first i with `req_vld[i]`, searching `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`.
  - At most one `req_ack` bit is high per cycle, and only the granted one.
  - `req_ack[g] = can_load & !rst` for granted g; all other bits are 0.
- On a load edge (`req_vld[g] & req_ack[g]`):
  - `out_pkt <= req_pkt[g]`, unmodified.
  - `out_vld <= 1`.
  - `ptr <= (g == N_REQ-1) ? 0 : g+1`.
- On `tran_done` with no load: `out_vld <= 0`; `out_pkt` keeps its last value.
- While `out_vld & !sw_rdy`: `out_pkt`, `out_vld` and `ptr` hold, and all `req_ack` are 0.
- Requester rule: hold `req_vld` and `req_pkt` stable until acked. Dropping `req_vld` before the ack is legal and withdraws the request; no packet is lost or duplicated.
- Two-state view: EMPTY (`out_vld=0`) and FULL (`out_vld=1`).
  - EMPTY→FULL on load.
  - FULL→FULL on `tran_done` with load, or on no `tran_done`.
  - FULL→EMPTY on `tran_done` without load.

## Timing
- Reset values: `out_vld=0`, `out_pkt=0`, `ptr=0`, `req_ack=0`, `stat_cnt=0`, `stall_max=0`.
- Latency: a packet acked on edge n appears on `out_pkt`/`out_vld` after edge n.
- Throughput: one packet per cycle while `sw_rdy=1` and requests are pending. Back-to-back loads happen on the same edge as `tran_done`, with no bubble.
- Reset mid-operation: a held packet is discarded, `out_vld` is 0 the cycle after the `rst` edge, and `ptr` returns to 0.
- `sw_rdy` while `out_vld=0` is ignored.
- With `N_REQ` not a power of two, `ptr` never exceeds `N_REQ-1`.

## Configuration
- `PE_INJ_ARB_STATS_EN` defined:
  - `stat_cnt[i]` increments on each `tran_done` whose packet came from requester i; a source index is stored alongside `out_pkt`.
  - Counters saturate at all-ones.
  - A stall counter counts consecutive `out_vld & !sw_rdy` cycles and resets on `tran_done`. `stall_max` tracks the maximum of that counter and saturates.
- Undefined: the stats logic, source-index register and both ports are absent. Arbitration behaviour is identical either way.

## Test plan
- Single requester: reset, then `req_vld=4'b0001`, `req_pkt[0]=16'h5003`, `sw_rdy=1` → `req_ack=4'b0001` for one cycle; next cycle `out_pkt=16'h5003`, `out_vld=1`; next cycle `out_vld=0`.
- Fairness: all four requesters continuously valid, `sw_rdy=1` → grant order 0,1,2,3,0,1 on consecutive cycles; `out_vld` stays 1 with no gaps.
- Backpressure: `out_pkt=16'hA101` loaded, `sw_rdy=0` for 5 cycles with all requests valid → `out_pkt` stable, `req_ack=0`. On the cycle `sw_rdy=1`, the next requester is acked and loaded on the same edge.
- Wrap and non-power-of-two: `N_REQ=3`, only requester 2 valid once, then requesters 0 and 2 valid → after granting 2, `ptr=0`, so requester 0 wins next.
- Reset mid-stall: `out_vld=1`, `sw_rdy=0`, assert `rst` for 1 cycle → `out_vld=0`, `ptr=0`, no `tran_done` counted.
- Stats (macro on): requester 1 sends 3 packets, including one stalled 7 cycles → `stat_cnt[1]=3`, other counts 0, `stall_max=7`.
